spi_reg_ctrl: RTL



---
 rtl/spi_reg_ctrl_pkg.sv | 15 +
 rtl/spi_reg_ctrl_if.sv | 28 ++
 rtl/spi_reg_ctrl_sync_2ff.sv | 24 ++
 rtl/spi_reg_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI register-bus transaction controller.
// The optional write lock is built in when SPI_REG_WLOCK_EN is defined.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_WDATA = 2'd1,
    ST_RWAIT = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  localparam int         CMD_READ_BIT = 7;
  localparam logic [7:0] WLOCK_KEY    = 8'h5A;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bundles the byte-level SPI slave side and the register bus of spi_reg_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7
);
  logic              ssel;
  logic              byte_received;
  logic [7:0]        received_data;
  logic              data_needed;
  logic [7:0]        data_to_send;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [7:0]        reg_rdata;
  logic              txn_active;
  logic              txn_done;

  modport slave (
    input  ssel, byte_received, received_data, data_needed, reg_rdata,
    output data_to_send, reg_addr, reg_wdata, reg_wr, reg_rd, txn_active, txn_done
  );

  modport master (
    output ssel, byte_received, received_data, data_needed, reg_rdata,
    input  data_to_send, reg_addr, reg_wdata, reg_wr, reg_rd, txn_active, txn_done
  );
endinterface

// File: rtl/spi_reg_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous control bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// Parses SSEL-framed SPI transfers into register-bus bursts and feeds MISO bytes.
// Define SPI_REG_WLOCK_EN to add the write lock keyed at the all-ones address.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input logic            clk,
  input logic            rst_n,
  spi_reg_ctrl_if.slave  bus
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q, state_d;
  logic [7:0]        data_to_send_q, data_to_send_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              wr_step_q, wr_step_d;
  logic              txn_active_q, txn_active_d;
  logic              txn_done_q, txn_done_d;
  logic              ssel_s;
  logic              rx;
  logic              cmd_read;
  logic [7:0]        status_now;
  logic              wr_allow;

  sync_2ff #(.RST_VAL(1'b1)) u_ssel_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.ssel),
    .q_o   (ssel_s)
  );

  assign rx       = bus.byte_received & ~ssel_s;
  assign cmd_read = bus.received_data[CMD_READ_BIT];

`ifdef SPI_REG_WLOCK_EN
  localparam logic [7:0] STATUS_RST = {STATUS_BYTE[7:1], 1'b1};
  logic locked_q, locked_d;

  assign status_now = {STATUS_BYTE[7:1], locked_q};
  assign wr_allow   = ~locked_q | (reg_addr_q == ADDR_MAX);

  // The key register itself is always writable so the lock can be opened.
  always_comb begin
    locked_d = locked_q;
    if (state_q == ST_WDATA && rx && reg_addr_q == ADDR_MAX)
      locked_d = (bus.received_data != WLOCK_KEY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked_q <= 1'b1;
    else        locked_q <= locked_d;
  end
`else
  localparam logic [7:0] STATUS_RST = STATUS_BYTE;
  assign status_now = STATUS_BYTE;
  assign wr_allow   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_CMD;
      data_to_send_q <= STATUS_RST;
      reg_addr_q     <= '0;
      reg_wdata_q    <= '0;
      reg_wr_q       <= 1'b0;
      reg_rd_q       <= 1'b0;
      wr_step_q      <= 1'b0;
      txn_active_q   <= 1'b0;
      txn_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      data_to_send_q <= data_to_send_d;
      reg_addr_q     <= reg_addr_d;
      reg_wdata_q    <= reg_wdata_d;
      reg_wr_q       <= reg_wr_d;
      reg_rd_q       <= reg_rd_d;
      wr_step_q      <= wr_step_d;
      txn_active_q   <= txn_active_d;
      txn_done_q     <= txn_done_d;
    end
  end

  // RWAIT lingers while the read strobe is out, so capture lands the clk after it.
  always_comb begin
    state_d = state_q;
    if (ssel_s) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_CMD:   if (rx) state_d = cmd_read ? ST_RWAIT : ST_WDATA;
        ST_WDATA: state_d = ST_WDATA;
        ST_RWAIT: if (!reg_rd_q) state_d = ST_RDATA;
        ST_RDATA: if (rx) state_d = ST_RWAIT;
        default:  state_d = ST_CMD;
      endcase
    end
  end

  always_comb begin
    data_to_send_d = data_to_send_q;
    reg_addr_d     = reg_addr_q;
    reg_wdata_d    = reg_wdata_q;
    reg_wr_d       = 1'b0;
    reg_rd_d       = 1'b0;
    wr_step_d      = 1'b0;
    txn_active_d   = txn_active_q;
    txn_done_d     = 1'b0;
    if (ssel_s) begin
      data_to_send_d = status_now;
      txn_active_d   = 1'b0;
      txn_done_d     = txn_active_q;
    end else begin
      if (wr_step_q) reg_addr_d = reg_addr_q + 1'b1;
      case (state_q)
        ST_CMD: begin
          data_to_send_d = status_now;
          if (rx) begin
            reg_addr_d   = bus.received_data[ADDR_W-1:0];
            txn_active_d = 1'b1;
            reg_rd_d     = cmd_read;
          end
        end
        ST_WDATA: if (rx) begin
          reg_wdata_d = bus.received_data;
          wr_step_d   = 1'b1;
          reg_wr_d    = wr_allow;
        end
        ST_RWAIT: if (!reg_rd_q) data_to_send_d = bus.reg_rdata;
        ST_RDATA: if (rx) begin
          reg_addr_d = reg_addr_q + 1'b1;
          reg_rd_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.data_to_send = data_to_send_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.reg_wdata    = reg_wdata_q;
  assign bus.reg_wr       = reg_wr_q;
  assign bus.reg_rd       = reg_rd_q;
  assign bus.txn_active   = txn_active_q;
  assign bus.txn_done     = txn_done_q;

  // The SPI slave may be mid-shift whenever data_needed is low.
  dts_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (!bus.data_needed && !$past(bus.data_needed)) |-> $stable(data_to_send_q));

endmodule
